// File: rtl/regfile_seq_pkg.sv
// Shared encodings and default geometry for the register-file command sequencer.
package regfile_seq_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_ZERO_REG = 31;
    localparam int COUNT_W      = 6;

    localparam logic [1:0] OP_FILL = 2'd0;
    localparam logic [1:0] OP_DUMP = 2'd1;
    localparam logic [1:0] OP_COPY = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DUMP,
        S_COPY,
        S_DONE
    } state_t;

endpackage

// File: rtl/regfile_seq_if.sv
// Command, register-file port and dump-stream signals of the sequencer, plus its state for observation.
interface regfile_seq_if
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    // Valid/ready: a transfer happens on a posedge where both are high; once valid
    // is raised its payload stays stable and valid stays high until that transfer.
    logic                CmdValid;
    logic                CmdReady;
    logic [1:0]          CmdOp;
    logic [ADDR_W-1:0]   CmdStart;
    logic [ADDR_W-1:0]   CmdDst;
    logic [COUNT_W-1:0]  CmdCount;
    logic [DATA_W-1:0]   CmdSeed;
    logic [DATA_W-1:0]   CmdStride;

    logic [ADDR_W-1:0]   RA;
    logic [ADDR_W-1:0]   RB;
    logic [DATA_W-1:0]   BusA;
    logic [DATA_W-1:0]   BusB;
    logic [ADDR_W-1:0]   RW;
    logic [DATA_W-1:0]   BusW;
    logic                RegWr;

    logic                OutValid;
    logic                OutReady;
    logic [DATA_W-1:0]   OutData;
    logic [ADDR_W-1:0]   OutAddr;
    logic                OutLast;

    logic                Busy;
    logic                Done;
    state_t              DbgState;

    modport master (
        input  CmdValid, CmdOp, CmdStart, CmdDst, CmdCount, CmdSeed, CmdStride,
        input  BusA, BusB, OutReady,
        output CmdReady, RA, RB, RW, BusW, RegWr,
        output OutValid, OutData, OutAddr, OutLast, Busy, Done, DbgState
    );

    modport slave (
        output CmdValid, CmdOp, CmdStart, CmdDst, CmdCount, CmdSeed, CmdStride,
        output BusA, BusB, OutReady,
        input  CmdReady, RA, RB, RW, BusW, RegWr,
        input  OutValid, OutData, OutAddr, OutLast, Busy, Done, DbgState
    );

endinterface

// File: rtl/regfile_seq_outbuf.sv
// One-entry ready/valid output register; payload holds while valid and not ready.
module regfile_seq_outbuf #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;

    // The parent only loads when the entry is empty or being consumed this cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            addr_d  = addr_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign addr_o  = addr_q;
    assign last_o  = last_q;

endmodule

// File: rtl/regfile_seq.sv
// Command-driven sequencer that fills, dumps or copies ranges of the 32x64 register file.
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic          Clk,
    input  logic          ResetN,
    regfile_seq_if.master bus
);

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    state_t              state_q, state_d;
    logic [COUNT_W-1:0]  k_q, k_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]   rw_q, rw_d;
    logic [DATA_W-1:0]   busw_q, busw_d;
    logic                regwr_q, regwr_d;
    logic [ADDR_W-1:0]   start_q, dst_q;
    logic [COUNT_W-1:0]  count_q;
    logic [DATA_W-1:0]   stride_q;

    logic [ADDR_W-1:0]   src_idx, dst_idx;
    logic                accept, last_k, dump_load;
    logic                out_valid, out_last;

    assign src_idx   = start_q + ADDR_W'(k_q);
    assign dst_idx   = dst_q + ADDR_W'(k_q);
    assign accept    = bus.CmdValid && (state_q == S_IDLE);
    assign last_k    = ((k_q + COUNT_W'(1)) == count_q);
    assign dump_load = (state_q == S_DUMP) && (k_q != count_q) && (!out_valid || bus.OutReady);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        rw_d    = rw_q;
        busw_d  = busw_q;
        regwr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.CmdValid) begin
                    k_d   = '0;
                    acc_d = bus.CmdSeed;
                    if (bus.CmdCount == '0) begin
                        state_d = S_DONE;
                    end else begin
                        case (bus.CmdOp)
                            OP_FILL: state_d = S_FILL;
                            OP_DUMP: state_d = S_DUMP;
                            OP_COPY: state_d = S_COPY;
                            default: state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_FILL: begin
                k_d   = k_q + COUNT_W'(1);
                acc_d = acc_q + stride_q;
                if (last_k) state_d = S_DONE;
            end
            S_DUMP: begin
                if (dump_load) k_d = k_q + COUNT_W'(1);
                if (out_valid && bus.OutReady && out_last) state_d = S_DONE;
            end
            S_COPY: begin
                // k == count is a drain cycle so the final registered write lands before DONE.
                if (k_q != count_q) begin
                    rw_d    = dst_idx;
                    busw_d  = bus.BusA;
                    regwr_d = (dst_idx != ZR);
                    k_d     = k_q + COUNT_W'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            acc_q    <= '0;
            rw_q     <= '0;
            busw_q   <= '0;
            regwr_q  <= 1'b0;
            start_q  <= '0;
            dst_q    <= '0;
            count_q  <= '0;
            stride_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            rw_q    <= rw_d;
            busw_q  <= busw_d;
            regwr_q <= regwr_d;
            if (accept) begin
                start_q  <= bus.CmdStart;
                dst_q    <= bus.CmdDst;
                count_q  <= bus.CmdCount;
                stride_q <= bus.CmdStride;
            end
        end
    end

    regfile_seq_outbuf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_outbuf (
        .clk_i   (Clk),
        .rst_ni  (ResetN),
        .load_i  (dump_load),
        .data_i  (bus.BusA),
        .addr_i  (src_idx),
        .last_i  (last_k),
        .ready_i (bus.OutReady),
        .valid_o (out_valid),
        .data_o  (bus.OutData),
        .addr_o  (bus.OutAddr),
        .last_o  (out_last)
    );

    // FILL writes are presented combinationally; COPY writes come from the registered path.
    assign bus.RegWr    = (state_q == S_FILL) ? (src_idx != ZR) : regwr_q;
    assign bus.RW       = (state_q == S_FILL) ? src_idx : rw_q;
    assign bus.BusW     = (state_q == S_FILL) ? acc_q : busw_q;
    assign bus.RA       = ((state_q == S_DUMP) || (state_q == S_COPY)) ? src_idx : '0;
    assign bus.RB       = ZR;
    assign bus.OutValid = out_valid;
    assign bus.OutLast  = out_last;
    assign bus.CmdReady = (state_q == S_IDLE);
    assign bus.Busy     = (state_q != S_IDLE);
    assign bus.Done     = (state_q == S_DONE);
    assign bus.DbgState = state_q;

endmodule
